// File: rtl/axis_crc_generator.sv
// AXI-Stream CRC-8 (poly 0x07) appender: forwards payload bytes, then emits the CRC byte with tlast.
// Optional packet counter output pkt_cnt_o is built when AXIS_CRC_GEN_STAT_EN is defined.
module axis_crc_generator #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [7:0]  CRC_INIT   = 8'h00
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] s_tdata_i,
  input  logic                  s_tvalid_i,
  input  logic                  s_tlast_i,
  output logic                  s_tready_o,
  output logic [DATA_WIDTH-1:0] m_tdata_o,
  output logic                  m_tvalid_o,
  output logic                  m_tlast_o,
  input  logic                  m_tready_i
`ifdef AXIS_CRC_GEN_STAT_EN
  ,
  output logic [15:0]           pkt_cnt_o
`endif
);

  localparam logic [0:0] ST_PASS   = 1'b0;
  localparam logic [0:0] ST_APPEND = 1'b1;

  // One byte of CRC-8/0x07 folded in parallel: d = crc ^ data, then d * x^8 mod P.
  function automatic logic [7:0] calc_crc(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] d;
    logic [7:0] c;
    d    = crc ^ data;
    c[0] = d[0] ^ d[6] ^ d[7];
    c[1] = d[0] ^ d[1] ^ d[6];
    c[2] = d[0] ^ d[1] ^ d[2] ^ d[6];
    c[3] = d[1] ^ d[2] ^ d[3] ^ d[7];
    c[4] = d[2] ^ d[3] ^ d[4];
    c[5] = d[3] ^ d[4] ^ d[5];
    c[6] = d[4] ^ d[5] ^ d[6];
    c[7] = d[5] ^ d[6] ^ d[7];
    return c;
  endfunction

  logic [0:0]            state_q, state_d;
  logic [7:0]            crc_q, crc_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  out_free;
  logic                  accept;

  assign out_free   = !tvalid_q || m_tready_i;
  assign s_tready_o = !rst_i && (state_q == ST_PASS) && out_free;
  assign accept     = s_tvalid_i && s_tready_o;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    crc_d    = crc_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    if (tvalid_q && m_tready_i) begin
      tvalid_d = 1'b0;
    end
    case (state_q)
      ST_PASS: begin
        if (accept) begin
          tdata_d  = s_tdata_i;
          tlast_d  = 1'b0;
          tvalid_d = 1'b1;
          crc_d    = calc_crc(crc_q, 8'(s_tdata_i));
          if (s_tlast_i) begin
            state_d = ST_APPEND;
          end
        end
      end
      default: begin
        // crc_q holds the finished CRC while waiting for the output register.
        if (out_free) begin
          tdata_d  = DATA_WIDTH'(crc_q);
          tlast_d  = 1'b1;
          tvalid_d = 1'b1;
          crc_d    = CRC_INIT;
          state_d  = ST_PASS;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst_i) begin
      state_q  <= ST_PASS;
      crc_q    <= CRC_INIT;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end

  assign m_tdata_o  = tdata_q;
  assign m_tvalid_o = tvalid_q;
  assign m_tlast_o  = tlast_q;

`ifdef AXIS_CRC_GEN_STAT_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (tvalid_q && tlast_q && m_tready_i) begin
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pkt_cnt_q <= 16'd0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign pkt_cnt_o = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_axis_crc_generator.sv
// Directed self-checking bench for axis_crc_generator; define AXIS_CRC_GEN_STAT_EN to also
// exercise the packet counter.
module tb_axis_crc_generator;

  localparam logic [7:0] CRC_INIT = 8'h00;

  logic       clk;
  logic       rst_i;
  logic [7:0] s_tdata_i;
  logic       s_tvalid_i;
  logic       s_tlast_i;
  logic       s_tready_o;
  logic [7:0] m_tdata_o;
  logic       m_tvalid_o;
  logic       m_tlast_o;
  logic       m_tready_i;
`ifdef AXIS_CRC_GEN_STAT_EN
  logic [15:0] pkt_cnt_o;
`endif

  axis_crc_generator #(
    .DATA_WIDTH(8),
    .CRC_INIT  (CRC_INIT)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .s_tdata_i (s_tdata_i),
    .s_tvalid_i(s_tvalid_i),
    .s_tlast_i (s_tlast_i),
    .s_tready_o(s_tready_o),
    .m_tdata_o (m_tdata_o),
    .m_tvalid_o(m_tvalid_o),
    .m_tlast_o (m_tlast_o),
    .m_tready_i(m_tready_i)
`ifdef AXIS_CRC_GEN_STAT_EN
    ,
    .pkt_cnt_o (pkt_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Bit-serial reference CRC-8, poly 0x07, MSB first.
  function automatic logic [7:0] crc8_ref(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // Output monitor: records every downstream handshake and tracks hold-while-stalled violations.
  logic [7:0] obs_data[$];
  logic       obs_last[$];
  int         stab_err = 0;
  logic       prev_v = 1'b0;
  logic       prev_r = 1'b0;
  logic       prev_l = 1'b0;
  logic [7:0] prev_d = 8'h00;
  longint     cyc = 0;
  bit         rand_ready = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_i) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        if (m_tvalid_o !== 1'b1 || m_tdata_o !== prev_d || m_tlast_o !== prev_l) stab_err++;
      end
      if (m_tvalid_o === 1'b1 && m_tready_i === 1'b1) begin
        obs_data.push_back(m_tdata_o);
        obs_last.push_back(m_tlast_o);
      end
      prev_v = m_tvalid_o;
      prev_r = m_tready_i;
      prev_d = m_tdata_o;
      prev_l = m_tlast_o;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      m_tready_i = 1'($urandom_range(0, 1));
    end
  end

  // Presents one beat and holds it until accepted; returns 1 ns after the accepting edge.
  task automatic drive_beat(input logic [7:0] d, input logic last, output bit ok);
    ok = 1'b0;
    s_tdata_i  = d;
    s_tlast_i  = last;
    s_tvalid_i = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (s_tready_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    s_tvalid_i = 1'b0;
    s_tlast_i  = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (obs_data.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic clear_obs();
    obs_data.delete();
    obs_last.delete();
  endtask

  task automatic test_reset();
    rst_i      = 1'b1;
    s_tvalid_i = 1'b1;
    m_tready_i = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (m_tvalid_o !== 1'b0) $display("FAIL reset_tvalid got=%b exp=0", m_tvalid_o);
    else n_pass++;
    n_checks++;
    if (m_tlast_o !== 1'b0) $display("FAIL reset_tlast got=%b exp=0", m_tlast_o);
    else n_pass++;
    n_checks++;
    if (m_tdata_o !== 8'h00) $display("FAIL reset_tdata got=%h exp=00", m_tdata_o);
    else n_pass++;
    n_checks++;
    if (s_tready_o !== 1'b0) $display("FAIL reset_tready got=%b exp=0", s_tready_o);
    else n_pass++;
`ifdef AXIS_CRC_GEN_STAT_EN
    n_checks++;
    if (pkt_cnt_o !== 16'd0) $display("FAIL reset_pkt_cnt got=%0d exp=0", pkt_cnt_o);
    else n_pass++;
`endif
    s_tvalid_i = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] exp_d[10] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
    bit ok;
    bit drv_ok = 1'b1;
    clear_obs();
    m_tready_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive_beat(exp_d[i], logic'(i == 8), ok);
      drv_ok &= ok;
    end
    wait_beats(10, 50, ok);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (!drv_ok || !ok || obs_data.size() != 10)
      $display("FAIL basic_count got=%0d exp=10 (drive_ok=%0b)", obs_data.size(), drv_ok);
    else n_pass++;
    for (int i = 0; i < 10 && i < obs_data.size(); i++) begin
      n_checks++;
      if (obs_data[i] !== exp_d[i] || obs_last[i] !== logic'(i == 9))
        $display("FAIL basic_beat%0d got=%h/%b exp=%h/%b", i, obs_data[i], obs_last[i],
                 exp_d[i], (i == 9));
      else n_pass++;
    end
  endtask

  task automatic test_one_byte();
    logic [7:0] exp_d[4] = '{8'h00, 8'h00, 8'h01, 8'h07};
    logic       exp_l[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    bit ok1, ok2, ok;
    clear_obs();
    m_tready_i = 1'b1;
    drive_beat(8'h00, 1'b1, ok1);
    drive_beat(8'h01, 1'b1, ok2);
    wait_beats(4, 50, ok);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (!ok1 || !ok2 || !ok || obs_data.size() != 4)
      $display("FAIL one_byte_count got=%0d exp=4", obs_data.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < obs_data.size(); i++) begin
      n_checks++;
      if (obs_data[i] !== exp_d[i] || obs_last[i] !== exp_l[i])
        $display("FAIL one_byte_beat%0d got=%h/%b exp=%h/%b", i, obs_data[i], obs_last[i],
                 exp_d[i], exp_l[i]);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp_d[10] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
    bit ok;
    bit drv_ok = 1'b1;
    clear_obs();
    stab_err   = 0;
    rand_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive_beat(exp_d[i], logic'(i == 8), ok);
      drv_ok &= ok;
    end
    wait_beats(10, 500, ok);
    repeat (5) @(posedge clk);
    rand_ready = 1'b0;
    #2;
    m_tready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (!drv_ok || !ok || obs_data.size() != 10)
      $display("FAIL stall_count got=%0d exp=10", obs_data.size());
    else n_pass++;
    for (int i = 0; i < 10 && i < obs_data.size(); i++) begin
      n_checks++;
      if (obs_data[i] !== exp_d[i] || obs_last[i] !== logic'(i == 9))
        $display("FAIL stall_beat%0d got=%h/%b exp=%h/%b", i, obs_data[i], obs_last[i],
                 exp_d[i], (i == 9));
      else n_pass++;
    end
    n_checks++;
    if (stab_err != 0) $display("FAIL stall_hold got=%0d violations exp=0", stab_err);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    bit ok;
    m_tready_i = 1'b1;
    for (int i = 0; i < 4; i++) drive_beat(8'h31 + 8'(i), 1'b0, ok);
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    clear_obs();
    drive_beat(8'h01, 1'b1, ok);
    wait_beats(2, 50, ok);
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (!ok || obs_data.size() != 2)
      $display("FAIL mid_reset_count got=%0d exp=2", obs_data.size());
    else n_pass++;
    if (obs_data.size() >= 2) begin
      n_checks++;
      if (obs_data[0] !== 8'h01 || obs_last[0] !== 1'b0)
        $display("FAIL mid_reset_beat0 got=%h/%b exp=01/0", obs_data[0], obs_last[0]);
      else n_pass++;
      n_checks++;
      if (obs_data[1] !== 8'h07 || obs_last[1] !== 1'b1)
        $display("FAIL mid_reset_beat1 got=%h/%b exp=07/1", obs_data[1], obs_last[1]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pay[6] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
    logic [7:0] exp_d[8];
    logic       exp_l[8];
    logic [7:0] c;
    longint     t_first = 0;
    longint     t_last  = 0;
    bit ok;
    bit drv_ok = 1'b1;
    c = CRC_INIT;
    for (int i = 0; i < 3; i++) c = crc8_ref(c, pay[i]);
    exp_d = '{8'h0A, 8'h0B, 8'h0C, c, 8'h0D, 8'h0E, 8'h0F, 8'h00};
    c = CRC_INIT;
    for (int i = 3; i < 6; i++) c = crc8_ref(c, pay[i]);
    exp_d[7] = c;
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    clear_obs();
    m_tready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_beat(pay[i], logic'(i == 2 || i == 5), ok);
      drv_ok &= ok;
      if (i == 0) t_first = cyc;
      if (i == 5) t_last = cyc;
    end
    wait_beats(8, 50, ok);
    repeat (3) @(posedge clk);
    #1;
    // Six beats plus the single CRC bubble: last accept is six cycles after the first.
    n_checks++;
    if (!drv_ok || t_last - t_first != 6)
      $display("FAIL b2b_spacing got=%0d exp=6", t_last - t_first);
    else n_pass++;
    n_checks++;
    if (!ok || obs_data.size() != 8) $display("FAIL b2b_count got=%0d exp=8", obs_data.size());
    else n_pass++;
    for (int i = 0; i < 8 && i < obs_data.size(); i++) begin
      n_checks++;
      if (obs_data[i] !== exp_d[i] || obs_last[i] !== exp_l[i])
        $display("FAIL b2b_beat%0d got=%h/%b exp=%h/%b", i, obs_data[i], obs_last[i],
                 exp_d[i], exp_l[i]);
      else n_pass++;
    end
  endtask

  task automatic test_sweep();
    bit ok;
    bit drv_ok = 1'b1;
    clear_obs();
    m_tready_i = 1'b1;
    for (int b = 0; b < 256; b++) begin
      drive_beat(8'(b), 1'b1, ok);
      drv_ok &= ok;
    end
    wait_beats(512, 200, ok);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (!drv_ok || !ok || obs_data.size() != 512)
      $display("FAIL sweep_count got=%0d exp=512", obs_data.size());
    else n_pass++;
    for (int b = 0; b < 256 && 2 * b + 1 < obs_data.size(); b++) begin
      n_checks++;
      if (obs_data[2*b] !== 8'(b) || obs_last[2*b] !== 1'b0 ||
          obs_data[2*b+1] !== crc8_ref(CRC_INIT, 8'(b)) || obs_last[2*b+1] !== 1'b1)
        $display("FAIL sweep_byte%h got=%h/%b,%h/%b exp=%h/0,%h/1", 8'(b), obs_data[2*b],
                 obs_last[2*b], obs_data[2*b+1], obs_last[2*b+1], 8'(b),
                 crc8_ref(CRC_INIT, 8'(b)));
      else n_pass++;
    end
  endtask

`ifdef AXIS_CRC_GEN_STAT_EN
  task automatic test_pkt_cnt();
    bit ok;
    bit drv_ok = 1'b1;
    m_tready_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    for (int p = 0; p < 65537; p++) begin
      drive_beat(8'h00, 1'b1, ok);
      drv_ok &= ok;
    end
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (!drv_ok || pkt_cnt_o !== 16'd1) $display("FAIL pkt_cnt_wrap got=%0d exp=1", pkt_cnt_o);
    else n_pass++;
  endtask
`endif

  initial begin
    rst_i      = 1'b1;
    s_tdata_i  = 8'h00;
    s_tvalid_i = 1'b0;
    s_tlast_i  = 1'b0;
    m_tready_i = 1'b1;
    test_reset();
    test_basic();
    test_one_byte();
    test_stall();
    test_mid_reset();
    test_back_to_back();
    test_sweep();
`ifdef AXIS_CRC_GEN_STAT_EN
    test_pkt_cnt();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
